// File: rtl/spi_reg_bridge_if.sv
// spi_reg_bridge_if
//   Bundles the word-level handshake between the SPI slave shift engine and
//   the command/register bridge, together with the bridge's register-bank
//   and write-notification outputs.
//
//   Signals:
//     cs_n         chip select, active low (frame boundary)
//     rx_data      received word from the shift engine
//     rx_valid     one-cycle strobe: rx_data holds a new word
//     tx_data      next word for the shift engine to transmit
//     reg_out      flattened register bank, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//     wr_strobe    one-cycle pulse per committed register write
//     wr_addr      address of the write flagged by wr_strobe
//     frame_active high while a frame is being decoded
//
//   Modports:
//     master  shift-engine / host side (drives cs_n, rx_data, rx_valid)
//     slave   bridge side
interface spi_reg_bridge_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic                           cs_n;
    logic [DATA_WIDTH-1:0]          rx_data;
    logic                           rx_valid;
    logic [DATA_WIDTH-1:0]          tx_data;
    logic [NUM_REGS*DATA_WIDTH-1:0] reg_out;
    logic                           wr_strobe;
    logic [ADDR_WIDTH-1:0]          wr_addr;
    logic                           frame_active;

    modport master (
        output cs_n,
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  reg_out,
        input  wr_strobe,
        input  wr_addr,
        input  frame_active
    );

    modport slave (
        input  cs_n,
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output reg_out,
        output wr_strobe,
        output wr_addr,
        output frame_active
    );
endinterface

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge
//   Command/register stage behind the SPI slave shift engine (sclk domain).
//   The first word of a frame is a command:
//     bit DATA_WIDTH-1 : W  (1 = write, 0 = read)
//     bit DATA_WIDTH-2 : AI (auto-increment pointer after each data word)
//     bits ADDR_WIDTH-1:0 : start address
//   Writes store the following word(s) into the register bank; reads place
//   register contents on tx_data for the shift engine to send while the
//   host clocks in dummy words.
//
//   Ports:
//     sclk  SPI clock, all state updates on its rising edge
//     rst   asynchronous active-high reset, clears everything incl. the bank
//     bus   spi_reg_bridge_if.slave (cs_n, rx_data, rx_valid, tx_data,
//           reg_out, wr_strobe, wr_addr, frame_active)
//
//   cs_n high asynchronously clears the framing state (FSM, pointer,
//   tx_data, wr_strobe) but leaves the register bank intact.
module spi_reg_bridge #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] FILL       = DATA_WIDTH'(8'hA5)
) (
    input logic             sclk,
    input logic             rst,
    spi_reg_bridge_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   ptr_reg, ptr_next;
    logic                    ai_reg, ai_next;
    logic [DATA_WIDTH-1:0]   tx_reg, tx_next;
    logic                    wr_strobe_reg;
    logic [ADDR_WIDTH-1:0]   wr_addr_reg;
    logic                    frame_active_reg;
    logic                    wr_en;

    logic [DATA_WIDTH-1:0]   bank_reg [NUM_REGS];

    // Command field decode (only meaningful in IDLE).
    logic                    cmd_w;
    logic                    cmd_ai;
    logic [ADDR_WIDTH-1:0]   cmd_addr;

    assign cmd_w    = bus.rx_data[DATA_WIDTH-1];
    assign cmd_ai   = bus.rx_data[DATA_WIDTH-2];
    assign cmd_addr = bus.rx_data[ADDR_WIDTH-1:0];

    // Next-state / datapath decode. Everything advances only on a received word.
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        ai_next    = ai_reg;
        tx_next    = tx_reg;
        wr_en      = 1'b0;

        if (bus.rx_valid) begin
            unique case (state_reg)
                S_IDLE: begin
                    ptr_next = cmd_addr;
                    ai_next  = cmd_ai;
                    if (cmd_w) begin
                        state_next = S_WRITE;
                    end else begin
                        // First read word is available for the very next transfer.
                        tx_next    = bank_reg[cmd_addr];
                        state_next = S_READ;
                        if (cmd_ai) begin
                            ptr_next = cmd_addr + PTR_ONE;
                        end
                    end
                end
                S_WRITE: begin
                    wr_en = 1'b1;
                    if (ai_reg) begin
                        ptr_next = ptr_reg + PTR_ONE;
                    end else begin
                        state_next = S_DONE;
                    end
                end
                S_READ: begin
                    // Incoming word is a dummy; only its arrival matters.
                    if (ai_reg) begin
                        tx_next  = bank_reg[ptr_reg];
                        ptr_next = ptr_reg + PTR_ONE;
                    end else begin
                        tx_next    = FILL;
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    tx_next = FILL;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Framing state: reset and chip-select both clear it asynchronously.
    // Testing cs_n before the clock path makes a word that arrives together
    // with cs_n rising get dropped.
    always_ff @(posedge sclk or posedge rst or posedge bus.cs_n) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            ptr_reg          <= '0;
            ai_reg           <= 1'b0;
            tx_reg           <= FILL;
            wr_strobe_reg    <= 1'b0;
            frame_active_reg <= 1'b0;
        end else if (bus.cs_n) begin
            state_reg        <= S_IDLE;
            ptr_reg          <= '0;
            ai_reg           <= 1'b0;
            tx_reg           <= FILL;
            wr_strobe_reg    <= 1'b0;
            frame_active_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            ptr_reg          <= ptr_next;
            ai_reg           <= ai_next;
            tx_reg           <= tx_next;
            wr_strobe_reg    <= wr_en;
            frame_active_reg <= (state_next != S_IDLE);
        end
    end

    // Write address survives frame clears so the last write stays visible.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            wr_addr_reg <= '0;
        end else if (wr_en && !bus.cs_n) begin
            wr_addr_reg <= ptr_reg;
        end
    end

    // Register bank: one flop word per address, cleared only by rst.
    // cs_n is sampled here so a write coinciding with cs_n rising is dropped.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bank
            always_ff @(posedge sclk or posedge rst) begin
                if (rst) begin
                    bank_reg[gi] <= '0;
                end else if (wr_en && !bus.cs_n && (ptr_reg == ADDR_WIDTH'(gi))) begin
                    bank_reg[gi] <= bus.rx_data;
                end
            end
            assign bus.reg_out[gi*DATA_WIDTH +: DATA_WIDTH] = bank_reg[gi];
        end
    endgenerate

    assign bus.tx_data      = tx_reg;
    assign bus.wr_strobe    = wr_strobe_reg;
    assign bus.wr_addr      = wr_addr_reg;
    assign bus.frame_active = frame_active_reg;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge
//   Directed and randomized frames against a transaction-level model of the
//   register bridge (an array of register values plus per-frame rules for
//   which addresses get written and what each transmitted word should be).
module tb_spi_reg_bridge;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NR = 16;
    localparam logic [7:0] FILL = 8'hA5;

    logic sclk;
    logic rst;

    spi_reg_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    spi_reg_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FILL(FILL)) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] model [NR];
    logic [7:0] words [8];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < NR; i++) f[i*8 +: 8] = model[i];
        return f;
    endfunction

    // One word through the shift engine: strobe for one cycle, sample #1 after the edge.
    task automatic send_word(input logic [7:0] d);
        @(negedge sclk);
        bus.rx_data  = d;
        bus.rx_valid = 1'b1;
        @(posedge sclk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge sclk);
        bus.cs_n = 1'b0;
    endtask

    task automatic end_frame(input string tag);
        @(negedge sclk);
        bus.cs_n = 1'b1;
        #1;
        check({tag, ".end.active"}, 128'(bus.frame_active), 128'(1'b0));
        check({tag, ".end.tx"},     128'(bus.tx_data), 128'(FILL));
        check({tag, ".end.regs"},   bus.reg_out, model_flat());
    endtask

    // Whole frame: command then n data words from words[].
    task automatic run_frame(input string tag, input logic [7:0] cmd, input int n);
        logic       w, ai;
        int         a, addr;
        logic [7:0] exp_tx;
        w  = cmd[7];
        ai = cmd[6];
        a  = int'(cmd[3:0]);
        start_frame();
        send_word(cmd);
        exp_tx = w ? FILL : model[a];
        check({tag, ".cmd.tx"},     128'(bus.tx_data), 128'(exp_tx));
        check({tag, ".cmd.active"}, 128'(bus.frame_active), 128'(1'b1));
        check({tag, ".cmd.strobe"}, 128'(bus.wr_strobe), 128'(1'b0));
        for (int k = 1; k <= n; k++) begin
            send_word(words[k-1]);
            if (w) begin
                if (ai || k == 1) begin
                    addr = (a + k - 1) % NR;
                    model[addr] = words[k-1];
                    check({tag, ".wr.strobe"}, 128'(bus.wr_strobe), 128'(1'b1));
                    check({tag, ".wr.addr"},   128'(bus.wr_addr), 128'(addr));
                end else begin
                    check({tag, ".ign.strobe"}, 128'(bus.wr_strobe), 128'(1'b0));
                end
                exp_tx = FILL;
            end else begin
                exp_tx = ai ? model[(a + k) % NR] : FILL;
                check({tag, ".rd.strobe"}, 128'(bus.wr_strobe), 128'(1'b0));
            end
            check({tag, ".word.tx"}, 128'(bus.tx_data), 128'(exp_tx));
            check({tag, ".word.active"}, 128'(bus.frame_active), 128'(1'b1));
        end
        @(posedge sclk);
        #1;
        check({tag, ".idle.strobe"}, 128'(bus.wr_strobe), 128'(1'b0));
        check({tag, ".idle.tx"},     128'(bus.tx_data), 128'(exp_tx));
        end_frame(tag);
    endtask

    initial begin
        logic [7:0] cmd;
        int         n;

        rst          = 1'b1;
        bus.cs_n     = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        for (int i = 0; i < NR; i++) model[i] = 8'h00;

        repeat (3) @(negedge sclk);
        check("reset.tx",     128'(bus.tx_data), 128'(FILL));
        check("reset.regs",   bus.reg_out, 128'(0));
        check("reset.strobe", 128'(bus.wr_strobe), 128'(1'b0));
        check("reset.waddr",  128'(bus.wr_addr), 128'(0));
        check("reset.active", 128'(bus.frame_active), 128'(1'b0));
        rst = 1'b0;
        $display("txn reset released");

        // Single write, third word ignored.
        words[0] = 8'h5C; words[1] = 8'hFF;
        run_frame("single_wr", 8'h83, 2);
        $display("txn single write reg[3]=5c");

        // Single read.
        words[0] = 8'h00;
        run_frame("single_rd", 8'h03, 1);
        $display("txn single read reg[3]");

        // Burst write wrapping 14 -> 15 -> 0.
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        run_frame("burst_wr_wrap", 8'hCE, 3);
        $display("txn burst write with wrap");

        // Burst read of reg[1..3] then reg[4].
        words[0] = 8'hA1; words[1] = 8'hA2; words[2] = 8'hA3;
        run_frame("preload_1_3", 8'hC1, 3);
        words[0] = 8'h00; words[1] = 8'h00; words[2] = 8'h00;
        run_frame("burst_rd", 8'h41, 3);
        $display("txn burst read reg[1..4]");

        // cs_n abort before any data word.
        words[0] = 8'h6B;
        run_frame("preload_5", 8'h85, 1);
        start_frame();
        send_word(8'h85);
        end_frame("abort");
        words[0] = 8'h00;
        run_frame("read_after_abort", 8'h05, 1);
        $display("txn abort then read reg[5]");

        // cs_n rising together with rx_valid: word dropped.
        start_frame();
        send_word(8'h83);
        @(negedge sclk);
        bus.rx_data  = 8'h77;
        bus.rx_valid = 1'b1;
        #4;
        bus.cs_n = 1'b1;
        @(posedge sclk);
        #1;
        bus.rx_valid = 1'b0;
        check("coincide.strobe", 128'(bus.wr_strobe), 128'(1'b0));
        check("coincide.active", 128'(bus.frame_active), 128'(1'b0));
        check("coincide.regs",   bus.reg_out, model_flat());
        $display("txn cs_n rise coincident with rx_valid");

        // Asynchronous reset in the middle of a burst write.
        start_frame();
        send_word(8'hC0);
        send_word(8'h12);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NR; i++) model[i] = 8'h00;
        check("rst_mid.tx",     128'(bus.tx_data), 128'(FILL));
        check("rst_mid.regs",   bus.reg_out, 128'(0));
        check("rst_mid.strobe", 128'(bus.wr_strobe), 128'(1'b0));
        check("rst_mid.active", 128'(bus.frame_active), 128'(1'b0));
        @(negedge sclk);
        bus.cs_n = 1'b1;
        @(negedge sclk);
        rst = 1'b0;
        $display("txn reset mid-burst");

        // Randomized frames.
        for (int f = 0; f < 60; f++) begin
            cmd = 8'($urandom);
            n   = int'($urandom_range(0, 5));
            for (int k = 0; k < 8; k++) words[k] = 8'($urandom);
            run_frame("rand", cmd, n);
            $display("txn random frame %0d cmd=%h words=%0d", f, cmd, n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
Command/register stage directly downstream of the SPI slave shift engine, in the sclk domain. It consumes received words (rx_data/rx_valid) and decodes a command word followed by data words. It maintains a bank of read/write configuration registers. It supplies the next transmit word (tx_data) back to the shift engine. It provides the host's register-level access path: single or auto-incrementing burst reads and writes.

Parameters:
DATA_WIDTH, 8, word width; must match the SPI slave shift engine.
ADDR_WIDTH, 4, register address width; NUM_REGS = 2**ADDR_WIDTH; requires ADDR_WIDTH <= DATA_WIDTH-2.
FILL, 8'hA5 (sized to DATA_WIDTH), word presented on tx_data when no read data is pending.

Ports:
sclk  in  1  SPI clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset; clears everything, including the register bank.
cs_n  in  1  chip select, active low; while high, asynchronously holds the framing FSM cleared (not the register bank).
rx_data  in  DATA_WIDTH  received word from the shift engine.
rx_valid  in  1  one-sclk-cycle strobe: rx_data holds a newly completed word.
tx_data  out  DATA_WIDTH  next word for the shift engine to transmit; stable between rx_valid strobes.
reg_out  out  NUM_REGS*DATA_WIDTH  register bank, flattened; register i at [i*DATA_WIDTH +: DATA_WIDTH].
wr_strobe  out  1  one-cycle pulse per committed register write.
wr_addr  out  ADDR_WIDTH  address of the write flagged by wr_strobe.
frame_active  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (rst=1, async): state IDLE, pointer 0, tx_data=FILL, all registers 0, wr_strobe=0, wr_addr=0, frame_active=0.
- Frame clear (cs_n=1, async, rst=0): state IDLE, pointer 0, tx_data=FILL. Registers and reg_out are retained; wr_strobe=0.
- Command word format: bit DW-1 W (1=write, 0=read); bit DW-2 AI (auto-increment); bits ADDR_WIDTH-1:0 address; remaining bits ignored.
- All transitions below happen only on posedge sclk with rx_valid=1 and cs_n=0. With rx_valid=0, state holds.
- FSM states: IDLE, WRITE, READ, DONE.
- IDLE, command received:
  - pointer <= address; latch AI.
  - If W=1: go to WRITE.
  - If W=0: tx_data <= reg[address]; pointer <= address+1 if AI; go to READ.
- WRITE, data word received:
  - reg[pointer] <= rx_data; wr_strobe=1 for exactly that cycle; wr_addr=pointer.
  - If AI: pointer increments and state stays WRITE.
  - Else: go to DONE.
- READ, word received: incoming word is a dummy and is discarded.
  - If AI: tx_data <= reg[pointer]; pointer increments; state stays READ.
  - Else: tx_data <= FILL; go to DONE.
- DONE: all further words ignored; tx_data=FILL until the frame clears.
- Pointer arithmetic is modulo NUM_REGS: address NUM_REGS-1 + 1 wraps to 0.
- Read data is sampled from the bank at the rx_valid edge. A read issued after a write in an earlier frame returns the new value.
- tx_data is registered: it changes only on the edge where rx_valid=1, and is valid from the following cycle onward.
- frame_active = (state != IDLE), registered.
- Simultaneous cs_n rising and rx_valid: the clear wins; the word is discarded.
- rst during a frame: everything is cleared, including registers. Frame decoding restarts with the next command after rst deasserts and cs_n is low.
- No combinational path from rx_data/rx_valid to any output.

Test Plan:
- Reset: assert rst mid-burst -> tx_data=8'hA5, reg_out all 0, wr_strobe=0, frame_active=0 immediately (asynchronous).
- Single write: cs_n=0, words 8'h83, 8'h5C -> reg[3]=8'h5C, one wr_strobe pulse with wr_addr=3. A third word 8'hFF is ignored: reg[4] unchanged, no strobe.
- Single read: preload reg[3]=8'h5C; words 8'h03, 8'h00 -> tx_data=8'h5C after the first rx_valid, 8'hA5 after the second.
- Burst write with wrap: 8'hCE, then 8'h11, 8'h22, 8'h33 -> reg[14]=8'h11, reg[15]=8'h22, reg[0]=8'h33; wr_addr sequence 14, 15, 0.
- Burst read: reg[1..3]=8'hA1, 8'hA2, 8'hA3; words 8'h41, dummy x3 -> tx_data sequence 8'hA1, 8'hA2, 8'hA3, then reg[4].
- cs_n abort: 8'h85 then raise cs_n before any data word -> FSM IDLE, reg[5] unchanged. Next frame 8'h05 reads the old reg[5]. Also drive cs_n rising coincident with rx_valid -> the word is dropped.
